audio_gain_ramp: RTL and testbench
==================================

AUDIO_GAIN_RAMP -- requirements
Module: audio_gain_ramp

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 64: accepted frames per one-LSB gain step (range 1..1023).
REQ-002 SHALL have port mclk, input, 1: single clock (22.579 MHz I2S main clock); all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1: one-cycle pulse, new stereo frame from the I2S receiver.
REQ-005 SHALL have port in_l / in_r, input, 16 each: signed two's-complement left/right samples, sampled when in_valid is accepted.
REQ-006 SHALL have port in_ready, output, 1: high only in state IDLE.
REQ-007 SHALL have port target_gain, input, 8: unsigned gain target, 128 = unity, 255 = max (about 1.99x).
REQ-008 SHALL have port mute, input, 1: forces the effective target to 0.
REQ-009 SHALL have port out_valid, output, 1: one-cycle pulse, processed frame ready for the I2S transmitter.
REQ-010 SHALL have port out_l / out_r, output, 16 each: signed processed samples, held until the next out_valid.
REQ-011 SHALL have port gain_settled, output, 1: cur_gain equals the effective target.
REQ-012 SHALL have port overrun, output, 1: sticky flag, set when in_valid arrives while in_ready is low.
REQ-013 SHALL have port clip, output, 1: sticky saturation flag (see Configuration).

Function
REQ-014 SHALL implement FSM IDLE -> MUL_L -> MUL_R -> OUT -> IDLE; IDLE -> MUL_L only on in_valid; every other transition is unconditional.
REQ-015 SHALL capture in_l, in_r and the current cur_gain into internal registers on acceptance (in_valid high in IDLE).
REQ-016 SHALL use one shared multiplier: MUL_L computes left, MUL_R computes right.
REQ-017 SHALL compute each channel as (signed 16-bit sample x {1'b0, gain}) as a 25-bit signed product, then arithmetic shift right by 7 (rounding toward negative infinity), then saturate to [-32768, 32767].
REQ-018 SHALL register out_l and out_r and pulse out_valid in state OUT; latency from the in_valid cycle to the out_valid cycle is exactly 3 clocks.
REQ-019 SHALL drop any frame arriving in MUL_L, MUL_R or OUT, with no change to the datapath, and set overrun.
REQ-020 SHALL define the effective target as 0 if mute is high, otherwise target_gain; mute and target_gain are sampled continuously.
REQ-021 SHALL increment a frame counter on each accepted frame, wrapping from RAMP_DIV-1 to 0.
REQ-022 SHALL, on that wrap, step cur_gain by exactly 1 toward the effective target, or leave it unchanged if equal; cur_gain never overshoots.
REQ-023 SHALL process a frame with the cur_gain value captured before that frame's gain step.
REQ-024 SHALL apply a change of target or mute mid-ramp from the next step onward, with no reset of the frame counter.
REQ-025 SHALL evaluate gain_settled combinationally from cur_gain and the effective target.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force: state IDLE, cur_gain 0, frame counter 0, out_l 0, out_r 0, out_valid 0, overrun 0, clip 0.
REQ-027 SHALL abort any in-flight frame on reset with no out_valid for it; the output ramps up from silence after reset release.
REQ-028 SHALL accept the first in_valid in the first clock after rst_n deasserts.

Configuration
REQ-029 SHALL use macro AUDIO_GAIN_CLIP_DETECT_EN: when defined, clip is set whenever either channel saturates and clears only on reset.
REQ-030 SHALL tie clip to constant 0 when AUDIO_GAIN_CLIP_DETECT_EN is undefined; saturation itself is always performed.

Verification
REQ-031 SHALL cover unity gain: RAMP_DIV=1, target 128, 128 frames to settle; then in_l=1000, in_r=-1000 -> out_l=1000, out_r=-1000, exactly 3 clocks after in_valid.
REQ-032 SHALL cover saturation: cur_gain 255; in_l=32767, in_r=-32768 -> out_l=32767, out_r=-32768; clip=1 with the macro defined, 0 without.
REQ-033 SHALL cover rounding: cur_gain 64, in_l=-3 -> out_l=-2; in_r=3 -> out_r=1.
REQ-034 SHALL cover ramp timing: RAMP_DIV=4, cur_gain 0, target 2 -> cur_gain=1 after frame 4 and 2 after frame 8; gain_settled rises then.
REQ-035 SHALL cover mute: settled at 128, mute=1, RAMP_DIV=1 -> cur_gain 0 after 128 frames; outputs then 0 for any input.
REQ-036 SHALL cover overrun and reset: in_valid 1 clock after an accepted one -> that frame dropped, overrun=1; rst_n low during MUL_R -> no out_valid, all flags 0.

Source files
------------

// File: rtl/audio_gain_ramp.sv
// -----------------------------------------------------------------------------
// audio_gain_ramp
//
// Stereo gain stage that sits between an I2S receiver and an I2S transmitter.
// Each accepted stereo frame is multiplied by the current gain. One shared
// multiplier handles the left channel and then the right channel. The gain is
// scaled so that 128 is unity, and the result is saturated to 16 bits.
//
// The applied gain (cur_gain) does not jump to the requested target. It moves
// by one LSB every RAMP_DIV accepted frames. This avoids the zipper noise that
// a step change in volume would cause. Because cur_gain starts at 0 after
// reset, the output always fades up from silence.
//
// Parameters
//   RAMP_DIV      accepted frames per one-LSB gain step (1..1023)
//
// Ports
//   mclk          I2S main clock; every register updates on its rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      one-cycle pulse: a new stereo frame is on in_l/in_r
//   in_l, in_r    signed 16-bit input samples
//   in_ready      high when a frame can be accepted (state IDLE)
//   target_gain   unsigned gain target, 128 = unity, 255 = about 1.99x
//   mute          forces the effective target to 0; cur_gain ramps down
//   out_valid     one-cycle pulse: a processed frame is on out_l/out_r
//   out_l, out_r  signed 16-bit processed samples, held between frames
//   gain_settled  cur_gain equals the effective target
//   overrun       sticky: a frame arrived while busy and was dropped
//   clip          sticky: a channel saturated (clip detection build only)
//
// Build option
//   AUDIO_GAIN_CLIP_DETECT_EN  when defined, clip records saturation events
//                              until reset. When undefined, clip is tied to 0.
//                              Saturation of the samples is always performed.
// -----------------------------------------------------------------------------
module audio_gain_ramp #(
   parameter int unsigned RAMP_DIV = 64
) (
   input  logic               mclk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic signed [15:0] in_l,
   input  logic signed [15:0] in_r,
   output logic               in_ready,
   input  logic [7:0]         target_gain,
   input  logic               mute,
   output logic               out_valid,
   output logic signed [15:0] out_l,
   output logic signed [15:0] out_r,
   output logic               gain_settled,
   output logic               overrun,
   output logic               clip
);

   // One frame takes four clocks, IDLE -> MUL_L -> MUL_R -> OUT.
   // out_valid is therefore high exactly 3 clocks after the in_valid cycle.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL_L = 2'd1,
      MUL_R = 2'd2,
      OUT   = 2'd3
   } state_t;

   localparam int CNT_W = 10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

   // Saturation limits, expressed at the width of the shifted product
   localparam logic signed [17:0] POS_LIM = 18'sd32767;
   localparam logic signed [17:0] NEG_LIM = -18'sd32768;

   state_t             state;
   logic [7:0]         cur_gain;
   logic [CNT_W-1:0]   frame_cnt;

   // Frame captured on acceptance, and the left result held until OUT
   logic signed [15:0] smp_l;
   logic signed [15:0] smp_r;
   logic [7:0]         gain_q;
   logic signed [15:0] res_l;

   logic [7:0]         eff_target;
   logic               accept;
   logic               cnt_wrap;
   logic signed [15:0] mul_a;
   logic signed [24:0] product;
   logic signed [17:0] scaled;
   logic signed [15:0] sat_val;

   // ---------------------------------------------------------------------
   // Control decode
   // ---------------------------------------------------------------------
   assign eff_target   = mute ? 8'd0 : target_gain;
   assign in_ready     = (state == IDLE);
   assign accept       = in_valid && (state == IDLE);
   assign cnt_wrap     = (frame_cnt == CNT_LAST);
   assign gain_settled = (cur_gain == eff_target);

   // ---------------------------------------------------------------------
   // Shared multiplier: selects the left sample in MUL_L and the right
   // sample in MUL_R. The gain gets a zero MSB so it is always read as
   // positive, which gives a 16 x 9 signed product that fits in 25 bits.
   // ---------------------------------------------------------------------
   assign mul_a   = (state == MUL_R) ? smp_r : smp_l;
   assign product = mul_a * $signed({1'b0, gain_q});

   // Dropping the 7 LSBs of a two's-complement value is an arithmetic shift,
   // so the result rounds toward negative infinity (-1.5 becomes -2).
   assign scaled  = product[24:7];

   // NOTE: every variable assigned in always_comb is given a default first.
   // Without the default, a path that skips the assignment infers a latch.
   always_comb begin
      sat_val = scaled[15:0];
      if (scaled > POS_LIM) begin
         sat_val = 16'sh7FFF;
      end else if (scaled < NEG_LIM) begin
         sat_val = -16'sh8000;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath capture registers
   // ---------------------------------------------------------------------
   // NOTE: these registers have no reset on purpose. Every frame overwrites
   // them on acceptance before anything reads them. Leaving the reset off
   // keeps the reset network smaller and has no effect on function.
   always_ff @(posedge mclk) begin
      if (accept) begin
         smp_l  <= in_l;
         smp_r  <= in_r;
         gain_q <= cur_gain;
      end
      if (state == MUL_L) begin
         res_l <= sat_val;
      end
   end

   // ---------------------------------------------------------------------
   // FSM, gain ramp and registered outputs
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. This way
   // every register samples values from before the clock edge, whatever
   // order the statements are written in.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_gain  <= 8'd0;
         frame_cnt <= '0;
         out_l     <= 16'sd0;
         out_r     <= 16'sd0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         out_valid <= 1'b0;

         // The busy states ignore a frame that arrives while busy. The frame
         // leaves no trace in the datapath. Only the sticky flag records it.
         if (in_valid && (state != IDLE)) begin
            overrun <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (in_valid) begin
                  state <= MUL_L;
                  // The frame keeps the gain it captured above. Any step
                  // taken here applies from the next frame onward.
                  if (cnt_wrap) begin
                     frame_cnt <= '0;
                     if (cur_gain < eff_target) begin
                        cur_gain <= cur_gain + 8'd1;
                     end else if (cur_gain > eff_target) begin
                        cur_gain <= cur_gain - 8'd1;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end

            MUL_L: begin
               state <= MUL_R;
            end

            MUL_R: begin
               // The right result comes straight from the multiplier. The
               // left result was stored one clock earlier.
               state     <= OUT;
               out_l     <= res_l;
               out_r     <= sat_val;
               out_valid <= 1'b1;
            end

            OUT: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Clip detection (optional)
   // ---------------------------------------------------------------------
`ifdef AUDIO_GAIN_CLIP_DETECT_EN
   logic sat_hit;
   logic clip_q;

   assign sat_hit = (scaled > POS_LIM) || (scaled < NEG_LIM);

   // The multiplier output is only meaningful while a channel is in flight.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         clip_q <= 1'b0;
      end else if (((state == MUL_L) || (state == MUL_R)) && sat_hit) begin
         clip_q <= 1'b1;
      end
   end

   assign clip = clip_q;
`else
   assign clip = 1'b0;
`endif

endmodule

// File: tb/tb_audio_gain_ramp.sv
// -----------------------------------------------------------------------------
// tb_audio_gain_ramp
//
// Scoreboard bench for audio_gain_ramp. It drives two instances:
//   dut0  RAMP_DIV = 1  unity, saturation, rounding, mute, overrun and reset
//   dut1  RAMP_DIV = 4  ramp timing
// A bench-side model of the gain ramp and the multiplier pushes the expected
// output of every accepted frame to a queue. A monitor on the falling clock
// edge pops that entry and compares it with the output, including the
// 3-clock latency.
// -----------------------------------------------------------------------------
module tb_audio_gain_ramp;

   logic               mclk = 1'b0;
   logic               rst_n;
   logic               iv   [2];
   logic signed [15:0] il   [2];
   logic signed [15:0] ir   [2];
   logic [7:0]         tg   [2];
   logic               mu   [2];
   logic               irdy [2];
   logic               ov   [2];
   logic signed [15:0] ol   [2];
   logic signed [15:0] orr  [2];
   logic               gs   [2];
   logic               ovr  [2];
   logic               clp  [2];

   always #22 mclk = ~mclk;

   audio_gain_ramp #(.RAMP_DIV(1)) dut0 (
      .mclk(mclk), .rst_n(rst_n), .in_valid(iv[0]), .in_l(il[0]), .in_r(ir[0]),
      .in_ready(irdy[0]), .target_gain(tg[0]), .mute(mu[0]), .out_valid(ov[0]),
      .out_l(ol[0]), .out_r(orr[0]), .gain_settled(gs[0]), .overrun(ovr[0]),
      .clip(clp[0])
   );

   audio_gain_ramp #(.RAMP_DIV(4)) dut1 (
      .mclk(mclk), .rst_n(rst_n), .in_valid(iv[1]), .in_l(il[1]), .in_r(ir[1]),
      .in_ready(irdy[1]), .target_gain(tg[1]), .mute(mu[1]), .out_valid(ov[1]),
      .out_l(ol[1]), .out_r(orr[1]), .gain_settled(gs[1]), .overrun(ovr[1]),
      .clip(clp[1])
   );

`ifdef AUDIO_GAIN_CLIP_DETECT_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   typedef struct {
      int l;
      int r;
      int cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0;
   exp_t e1;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   int m_gain [2];
   int m_cnt  [2];
   bit m_clip [2];

   always @(posedge mclk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------
   // Comparison helpers
   // ---------------------------------------------------------------------
   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %b, expected %b", tag, obs, exp_v);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   function automatic int div_of(input int u);
      return (u == 0) ? 1 : 4;
   endfunction

   function automatic int eff_of(input int u);
      return mu[u] ? 0 : int'(tg[u]);
   endfunction

   function automatic bit model_settled(input int u);
      return m_gain[u] == eff_of(u);
   endfunction

   function automatic int model_mul(input int u, input int s, input int g);
      int q;
      q = (s * g) >>> 7;
      if (q > 32767) begin
         q = 32767;
         if (CLIP_EN) m_clip[u] = 1'b1;
      end else if (q < -32768) begin
         q = -32768;
         if (CLIP_EN) m_clip[u] = 1'b1;
      end
      return q;
   endfunction

   // Records the expected output of an accepted frame, then advances the ramp.
   task automatic push_exp(input int u, input int l, input int r);
      exp_t e;
      e.l   = model_mul(u, l, m_gain[u]);
      e.r   = model_mul(u, r, m_gain[u]);
      e.cyc = cyc;
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
      if (m_cnt[u] == div_of(u) - 1) begin
         m_cnt[u] = 0;
         if (m_gain[u] < eff_of(u))      m_gain[u]++;
         else if (m_gain[u] > eff_of(u)) m_gain[u]--;
      end else begin
         m_cnt[u]++;
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_gain[u] = 0;
         m_cnt[u]  = 0;
         m_clip[u] = 1'b0;
      end
   endtask

   // Called on a falling edge. Drives a one-cycle frame and returns on the
   // falling edge after the frame's OUT state, when the DUT is back in IDLE.
   task automatic drive_frame(input int u, input int l, input int r);
      iv[u] = 1'b1;
      il[u] = 16'(l);
      ir[u] = 16'(r);
      push_exp(u, l, r);
      @(negedge mclk);
      iv[u] = 1'b0;
      repeat (3) @(negedge mclk);
   endtask

   task automatic send(input int u, input int l, input int r);
      @(negedge mclk);
      drive_frame(u, l, r);
   endtask

   // ---------------------------------------------------------------------
   // Output monitors
   // ---------------------------------------------------------------------
   always @(negedge mclk) begin
      if (ov[0] === 1'b1) begin
         if (q0.size() == 0) begin
            check_bit("dut0_unexpected_out_valid", 1'b1, 1'b0);
         end else begin
            e0 = q0.pop_front();
            check("dut0_out_l", 32'(ol[0]), e0.l);
            check("dut0_out_r", 32'(orr[0]), e0.r);
            check("dut0_latency", cyc, e0.cyc + 3);
         end
      end
   end

   always @(negedge mclk) begin
      if (ov[1] === 1'b1) begin
         if (q1.size() == 0) begin
            check_bit("dut1_unexpected_out_valid", 1'b1, 1'b0);
         end else begin
            e1 = q1.pop_front();
            check("dut1_out_l", 32'(ol[1]), e1.l);
            check("dut1_out_r", 32'(orr[1]), e1.r);
            check("dut1_latency", cyc, e1.cyc + 3);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------
   initial begin
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         iv[u] = 1'b0;
         il[u] = 16'sd0;
         ir[u] = 16'sd0;
         mu[u] = 1'b0;
      end
      tg[0] = 8'd128;
      tg[1] = 8'd2;
      model_reset();

      // Reset state
      repeat (3) @(negedge mclk);
      check_bit("rst_out_valid", ov[0], 1'b0);
      check_bit("rst_overrun", ovr[0], 1'b0);
      check_bit("rst_clip", clp[0], 1'b0);
      check_bit("rst_in_ready", irdy[0], 1'b1);
      check_bit("rst_settled", gs[0], 1'b0);
      check("rst_out_l", 32'(ol[0]), 0);
      check("rst_out_r", 32'(orr[0]), 0);
      rst_n = 1'b1;

      // Ramp timing on the RAMP_DIV=4 instance: the gain steps after frames 4 and 8
      for (int i = 1; i <= 9; i++) begin
         send(1, 128, -128);
         check_bit("ramp4_settled", gs[1], model_settled(1));
      end

      // Unity: 128 frames to settle at 128, then pass-through
      for (int i = 0; i < 128; i++) send(0, 128, -128);
      check_bit("unity_settled", gs[0], model_settled(0));
      send(0, 1000, -1000);

      // Saturation at gain 255
      tg[0] = 8'd255;
      #1 check_bit("sat_unsettled", gs[0], model_settled(0));
      for (int i = 0; i < 127; i++) send(0, 0, 0);
      check_bit("sat_settled", gs[0], model_settled(0));
      check_bit("clip_before_sat", clp[0], 1'b0);
      send(0, 32767, -32768);
      check_bit("clip_after_sat", clp[0], m_clip[0]);

      // Rounding toward negative infinity at gain 64
      tg[0] = 8'd64;
      for (int i = 0; i < 191; i++) send(0, 0, 0);
      check_bit("round_settled", gs[0], model_settled(0));
      send(0, -3, 3);

      // Mute: back to 128, then ramp down to 0
      tg[0] = 8'd128;
      for (int i = 0; i < 64; i++) send(0, 0, 0);
      check_bit("premute_settled", gs[0], model_settled(0));
      mu[0] = 1'b1;
      #1 check_bit("mute_unsettled", gs[0], model_settled(0));
      for (int i = 0; i < 128; i++) send(0, 0, 0);
      check_bit("mute_settled", gs[0], model_settled(0));
      send(0, 12345, -32768);
      check_bit("mute_clip_sticky", clp[0], m_clip[0]);

      // Overrun: a second frame one clock after an accepted one is dropped
      mu[0] = 1'b0;
      for (int i = 0; i < 4; i++) send(0, 128, 128);
      @(negedge mclk);
      iv[0] = 1'b1;
      il[0] = 16'sd128;
      ir[0] = 16'sd1000;
      push_exp(0, 128, 1000);
      @(negedge mclk);
      check_bit("busy_in_ready", irdy[0], 1'b0);
      il[0] = 16'sd999;
      ir[0] = 16'sd999;
      @(negedge mclk);
      iv[0] = 1'b0;
      repeat (2) @(negedge mclk);
      check_bit("overrun_set", ovr[0], 1'b1);
      send(0, 128, 128);

      // Reset while in MUL_R: the frame must never emerge
      @(negedge mclk);
      iv[0] = 1'b1;
      il[0] = 16'sd500;
      ir[0] = 16'sd500;
      @(negedge mclk);
      iv[0] = 1'b0;
      @(negedge mclk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_bit("midrst_out_valid", ov[0], 1'b0);
      check_bit("midrst_overrun", ovr[0], 1'b0);
      check_bit("midrst_clip", clp[0], 1'b0);
      check_bit("midrst_in_ready", irdy[0], 1'b1);
      check("midrst_out_l", 32'(ol[0]), 0);
      check("midrst_out_r", 32'(orr[0]), 0);
      repeat (3) @(negedge mclk);

      // The first clock after release accepts a frame; the output fades up from silence
      rst_n = 1'b1;
      drive_frame(0, 128, 128);
      send(0, 128, 128);
      send(0, 128, 128);
      check_bit("post_rst_overrun", ovr[0], 1'b0);

      // Bounded wait for the scoreboard to drain
      for (int k = 0; k < 10 && (q0.size() + q1.size()) != 0; k++) @(negedge mclk);
      check("scoreboard_drained", q0.size() + q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
